// File: rtl/game_timer_pkg.sv
// Shared types and defaults for the frame timer scheduler.
package game_timer_pkg;
  localparam int NUM_SLOTS_DEF = 4;
  localparam int TIME_W_DEF    = 4;
  localparam int ID_W          = 2;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending slot after last_served, wrapping.
module rr_arbiter
  import game_timer_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF
) (
  input  logic [NUM_SLOTS-1:0] pending,
  input  logic [ID_W-1:0]      last_served,
  output logic [NUM_SLOTS-1:0] grant,
  output logic [ID_W-1:0]      grant_idx,
  output logic                 grant_vld
);
  int s;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    s         = 0;
    for (int off = 1; off <= NUM_SLOTS; off++) begin
      s = (int'(last_served) + off) % NUM_SLOTS;
      if (!grant_vld && pending[s]) begin
        grant[s]  = 1'b1;
        grant_idx = ID_W'(s);
        grant_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/timer_scheduler.sv
// Shares one frame countdown unit among NUM_SLOTS requesters, round-robin,
// with per-slot cancel and a startOfFrame watchdog on each grant.
module timer_scheduler
  import game_timer_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int TIME_W    = TIME_W_DEF
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_SLOTS-1:0]        req,
  input  logic [NUM_SLOTS*TIME_W-1:0] req_time,
  input  logic [NUM_SLOTS-1:0]        cancel,
  output logic                        timer_start,
  output logic [TIME_W-1:0]           timer_time,
  input  logic                        timer_done,
  output logic [NUM_SLOTS-1:0]        done,
  output logic [NUM_SLOTS-1:0]        busy,
  output logic [ID_W-1:0]             active_id,
  output logic                        timeout_err
);
  sched_state_t state, state_nxt;

  logic [NUM_SLOTS-1:0]             pending, pending_nxt, pending_clr, accept;
  logic [NUM_SLOTS-1:0][TIME_W-1:0] delay_q;
  logic [ID_W-1:0]                  last_served, last_nxt, active_nxt;
  logic                             cancelled, cancelled_nxt, cancel_act;
  logic [TIME_W+1:0]                wd_cnt, wd_nxt, wd_limit;
  logic                             timeout_nxt, start_nxt;
  logic [TIME_W-1:0]                time_nxt;
  logic [NUM_SLOTS-1:0]             done_nxt, active_oh;
  logic [NUM_SLOTS-1:0]             gnt_oh;
  logic [ID_W-1:0]                  gnt_idx;
  logic                             gnt_vld;

  assign active_oh  = NUM_SLOTS'(1) << active_id;
  assign cancel_act = cancel[active_id];
  assign wd_limit   = (TIME_W+2)'(timer_time) + (TIME_W+2)'(2);
  assign busy       = pending | ((state != IDLE && !cancelled) ? active_oh : '0);

  // A same-cycle cancel removes the slot from arbitration too.
  rr_arbiter #(.NUM_SLOTS(NUM_SLOTS)) u_arb (
    .pending     (pending & ~cancel),
    .last_served (last_served),
    .grant       (gnt_oh),
    .grant_idx   (gnt_idx),
    .grant_vld   (gnt_vld)
  );

  // The active slot may re-request in the cycle its expiry arrives.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      accept[i] = req[i] & (~busy[i] |
                  (state == WAIT && timer_done && active_id == ID_W'(i)));
  end

  always_comb begin
    state_nxt     = state;
    pending_clr   = '0;
    active_nxt    = active_id;
    last_nxt      = last_served;
    cancelled_nxt = cancelled;
    wd_nxt        = wd_cnt;
    timeout_nxt   = timeout_err;
    start_nxt     = 1'b0;
    time_nxt      = timer_time;
    done_nxt      = '0;
    case (state)
      IDLE: begin
        wd_nxt        = '0;
        cancelled_nxt = 1'b0;
        if (gnt_vld) begin
          active_nxt  = gnt_idx;
          pending_clr = gnt_oh;
          time_nxt    = delay_q[gnt_idx];
          state_nxt   = LAUNCH;
        end
      end
      LAUNCH: begin
        start_nxt = 1'b1;
        state_nxt = WAIT;
        if (cancel_act) cancelled_nxt = 1'b1;
      end
      WAIT: begin
        if (cancel_act) cancelled_nxt = 1'b1;
        if (timer_done) begin
          if (!cancelled && !cancel_act) done_nxt = active_oh;
          last_nxt   = active_id;
          active_nxt = '0;
          state_nxt  = IDLE;
        end else if (startOfFrame) begin
          wd_nxt = wd_cnt + 1'b1;
          if (wd_nxt == wd_limit) begin
            timeout_nxt = 1'b1;
            last_nxt    = active_id;
            active_nxt  = '0;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    pending_nxt = ((pending & ~pending_clr) | accept) & ~cancel;
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending     <= '0;
      delay_q     <= '0;
      last_served <= ID_W'(NUM_SLOTS - 1);
      active_id   <= '0;
      cancelled   <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      timer_start <= 1'b0;
      timer_time  <= '0;
      done        <= '0;
    end else begin
      pending     <= pending_nxt;
      last_served <= last_nxt;
      active_id   <= active_nxt;
      cancelled   <= cancelled_nxt;
      wd_cnt      <= wd_nxt;
      timeout_err <= timeout_nxt;
      timer_start <= start_nxt;
      timer_time  <= time_nxt;
      done        <= done_nxt;
      for (int i = 0; i < NUM_SLOTS; i++)
        if (accept[i]) delay_q[i] <= req_time[i*TIME_W +: TIME_W];
    end
  end
endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler: expected launches/dones queued at stimulus time.
module tb_timer_scheduler;
  localparam int NS = 4;
  localparam int TW = 4;

  typedef struct packed {
    logic [1:0]    slot;
    logic [TW-1:0] tm;
  } launch_t;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic [NS-1:0]      req = '0;
  logic [NS*TW-1:0]   req_time = '0;
  logic [NS-1:0]      cancel = '0;
  logic               timer_start;
  logic [TW-1:0]      timer_time;
  logic               timer_done = 1'b0;
  logic [NS-1:0]      done;
  logic [NS-1:0]      busy;
  logic [1:0]         active_id;
  logic               timeout_err;

  int      errors = 0;
  int      checks = 0;
  launch_t exp_launch[$];
  logic [NS-1:0] exp_done[$];
  logic    prev_start = 1'b0;

  timer_scheduler #(.NUM_SLOTS(NS), .TIME_W(TW)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .req          (req),
    .req_time     (req_time),
    .cancel       (cancel),
    .timer_start  (timer_start),
    .timer_time   (timer_time),
    .timer_done   (timer_done),
    .done         (done),
    .busy         (busy),
    .active_id    (active_id),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_l(input int s, input int t);
    launch_t e;
    e.slot = 2'(s);
    e.tm   = TW'(t);
    exp_launch.push_back(e);
  endtask

  task automatic pulse_req(input logic [NS-1:0] m, input logic [NS*TW-1:0] t);
    req = m;
    req_time = t;
    tick();
    req = '0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!timer_start && n < 20) begin
      tick();
      n++;
    end
    if (!timer_start) check("start_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #1;
    exp_launch.delete();
    exp_done.delete();
    check("rst_start", 32'(timer_start), 32'(0));
    check("rst_time",  32'(timer_time),  32'(0));
    check("rst_done",  32'(done),        32'(0));
    check("rst_busy",  32'(busy),        32'(0));
    check("rst_id",    32'(active_id),   32'(0));
    check("rst_tmo",   32'(timeout_err), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  task automatic run_grant(input int slot, input int tm, input bit cx);
    logic [NS-1:0] oh;
    oh = NS'(1) << slot;
    wait_start();
    check("grant_id",   32'(active_id), 32'(slot));
    check("grant_time", 32'(timer_time), 32'(tm));
    check("grant_busy", 32'(busy[slot]), 32'(1));
    if (cx) begin
      cancel = oh;
      tick();
      cancel = '0;
      check("cx_busy", 32'(busy[slot]), 32'(0));
    end
    tick();
    tick();
    timer_done = 1'b1;
    if (!cx) exp_done.push_back(oh);
    tick();
    timer_done = 1'b0;
    check("grant_done", 32'(done), cx ? 32'(0) : 32'(oh));
    tick();
  endtask

  // Scoreboard: every launch/done from the DUT must match the next queued expectation.
  always @(negedge clk) begin
    if (resetN) begin
      if (timer_start) begin
        check("start_double", 32'(prev_start), 32'(0));
        if (exp_launch.size() == 0) check("launch_unexpected", 32'(1), 32'(0));
        else begin
          check("sb_launch_id",   32'(active_id),  32'(exp_launch[0].slot));
          check("sb_launch_time", 32'(timer_time), 32'(exp_launch[0].tm));
          void'(exp_launch.pop_front());
        end
      end
      if (done != '0) begin
        if (exp_done.size() == 0) check("done_unexpected", 32'(done), 32'(0));
        else begin
          check("sb_done", 32'(done), 32'(exp_done[0]));
          void'(exp_done.pop_front());
        end
      end
    end
    prev_start <= timer_start;
  end

  initial begin
    #2;
    do_reset();

    // Single request: exact launch latency and done/busy timing.
    exp_l(0, 3);
    pulse_req(4'b0001, 16'h0003);
    check("t1_busy", 32'(busy), 32'(4'b0001));
    check("t1_start_k0", 32'(timer_start), 32'(0));
    tick();
    check("t1_start_k1", 32'(timer_start), 32'(0));
    tick();
    check("t1_start_k2", 32'(timer_start), 32'(1));
    check("t1_time", 32'(timer_time), 32'(3));
    tick();
    check("t1_start_once", 32'(timer_start), 32'(0));
    timer_done = 1'b1;
    exp_done.push_back(4'b0001);
    tick();
    timer_done = 1'b0;
    check("t1_done", 32'(done), 32'(4'b0001));
    check("t1_busy_lo", 32'(busy), 32'(0));
    tick();
    check("t1_done_once", 32'(done), 32'(0));

    // All four at once from reset: served 0,1,2,3.
    do_reset();
    for (int i = 0; i < NS; i++) exp_l(i, i + 1);
    pulse_req(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1});
    for (int i = 0; i < NS; i++) run_grant(i, i + 1, 1'b0);

    // Round robin: after slot 0, slot 1 goes before slot 0.
    do_reset();
    exp_l(0, 5);
    pulse_req(4'b0001, 16'h0005);
    run_grant(0, 5, 1'b0);
    exp_l(1, 7);
    exp_l(0, 6);
    pulse_req(4'b0011, {4'd0, 4'd0, 4'd7, 4'd6});
    run_grant(1, 7, 1'b0);
    run_grant(0, 6, 1'b0);

    // Cancel the active slot 2; repeat request on pending slot 3 is ignored.
    exp_l(2, 5);
    exp_l(3, 6);
    pulse_req(4'b1100, {4'd6, 4'd5, 4'd0, 4'd0});
    pulse_req(4'b1000, {4'd9, 4'd0, 4'd0, 4'd0});
    run_grant(2, 5, 1'b1);
    run_grant(3, 6, 1'b0);

    // Re-request on the expiry cycle of the same slot.
    exp_l(1, 2);
    pulse_req(4'b0010, {4'd0, 4'd0, 4'd2, 4'd0});
    wait_start();
    tick();
    timer_done = 1'b1;
    req = 4'b0010;
    req_time = {4'd0, 4'd0, 4'd7, 4'd0};
    exp_done.push_back(4'b0010);
    exp_l(1, 7);
    tick();
    timer_done = 1'b0;
    req = '0;
    check("rereq_done", 32'(done), 32'(4'b0010));
    check("rereq_busy", 32'(busy), 32'(4'b0010));
    run_grant(1, 7, 1'b0);

    // Zero delay launches normally.
    exp_l(2, 0);
    pulse_req(4'b0100, 16'h0000);
    run_grant(2, 0, 1'b0);

    // Watchdog: delay 2, no expiry, fourth frame strobe times out.
    do_reset();
    exp_l(0, 2);
    pulse_req(4'b0001, 16'h0002);
    wait_start();
    for (int s = 1; s <= 4; s++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      if (s == 3) check("wd_early", 32'(timeout_err), 32'(0));
      if (s < 4) tick();
    end
    check("wd_err",  32'(timeout_err), 32'(1));
    check("wd_busy", 32'(busy), 32'(0));
    check("wd_id",   32'(active_id), 32'(0));
    tick();
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    check("wd_late_done", 32'(done), 32'(0));
    check("wd_sticky", 32'(timeout_err), 32'(1));

    // Reset mid-WAIT with slots 1 and 3 still pending.
    do_reset();
    exp_l(0, 4);
    pulse_req(4'b1011, {4'd1, 4'd0, 4'd1, 4'd4});
    wait_start();
    tick();
    check("mid_busy", 32'(busy), 32'(4'b1011));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("post_rst_busy",  32'(busy), 32'(0));
      check("post_rst_start", 32'(timer_start), 32'(0));
      tick();
    end
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    check("post_rst_done", 32'(done), 32'(0));
    tick();
    check("post_rst_idle", 32'(timer_start), 32'(0));

    tick();
    check("sb_leftover", 32'(exp_launch.size() + exp_done.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of requesters sharing the frame countdown unit.
REQ-002 SHALL have parameter TIME_W, default 4, width of a delay value in frames.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 resetN  in  1  reset, asynchronous, active-low.
REQ-005 startOfFrame  in  1  one-cycle frame strobe; used only for the watchdog.
REQ-006 req  in  NUM_SLOTS  per-slot one-cycle request pulse.
REQ-007 req_time  in  NUM_SLOTS*TIME_W  packed per-slot delay; slot i occupies bits [i*TIME_W +: TIME_W].
REQ-008 cancel  in  NUM_SLOTS  per-slot one-cycle cancel pulse.
REQ-009 timer_start  out  1  one-cycle launch pulse to the shared countdown unit.
REQ-010 timer_time  out  TIME_W  delay for the countdown unit; valid while timer_start=1.
REQ-011 timer_done  in  1  one-cycle expiry pulse from the countdown unit.
REQ-012 done  out  NUM_SLOTS  per-slot one-cycle expiry pulse to the owner.
REQ-013 busy  out  NUM_SLOTS  slot pending or active.
REQ-014 active_id  out  2  slot currently owning the countdown unit; 0 when idle.
REQ-015 timeout_err  out  1  sticky flag, watchdog fired.

Function
REQ-016 SHALL keep per slot a pending bit and a latched TIME_W delay.
REQ-017 req[i] with slot i not busy SHALL set pending[i] and latch req_time slice i on the same edge.
REQ-018 req[i] while slot i busy SHALL be ignored; the original delay is kept.
REQ-019 cancel[i] SHALL clear pending[i]; cancel wins over req[i] in the same cycle.
REQ-020 FSM states: IDLE, LAUNCH, WAIT.
REQ-021 IDLE: if any pending, SHALL pick a slot round-robin starting at last_served+1 (mod NUM_SLOTS), register it as active_id, clear its pending bit, load timer_time, go to LAUNCH.
REQ-022 LAUNCH: timer_start=1 for exactly one cycle; go to WAIT.
REQ-023 Latency: req pulse at edge k into an idle scheduler SHALL give timer_start=1 during the cycle after edge k+2.
REQ-024 WAIT: on timer_done, SHALL pulse done[active_id] on the next cycle (unless cancelled), set last_served=active_id, return to IDLE.
REQ-025 cancel[active_id] in WAIT SHALL mark the grant cancelled; the following timer_done SHALL produce no done pulse but SHALL still free the unit.
REQ-026 busy[i] = pending[i] OR (state!=IDLE AND active_id==i AND not cancelled).
REQ-027 req[i] in the cycle timer_done arrives for active slot i SHALL be latched as a new pending request; done[i] still pulses for the old one.
REQ-028 timer_done in IDLE or LAUNCH SHALL be ignored.
REQ-029 Watchdog: in WAIT, a TIME_W+2-bit counter SHALL count startOfFrame strobes; reaching latched delay+2 without timer_done SHALL set timeout_err, drop the grant without done, return to IDLE.
REQ-030 Delay 0 SHALL be launched normally (countdown unit expires immediately).
REQ-031 At most one done bit SHALL be high in any cycle; timer_start SHALL never be high two consecutive cycles.

Reset
REQ-032 resetN low SHALL asynchronously force: state IDLE, pending=0, latched delays=0, last_served=NUM_SLOTS-1 (slot 0 served first), timer_start=0, timer_time=0, done=0, busy=0, active_id=0, timeout_err=0, watchdog=0.
REQ-033 Reset mid-WAIT SHALL discard the grant; a later timer_done SHALL be ignored.

Structure
REQ-034 Package game_timer_pkg SHALL hold NUM_SLOTS, TIME_W defaults and enum sched_state_t {IDLE, LAUNCH, WAIT}.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (pending vector + last_served in, one-hot grant + index out, combinational).

Verification
REQ-036 req=0001, time0=3 -> timer_start one pulse 2 cycles later with timer_time=3; timer_done -> done=0001 next cycle; busy[0] low.
REQ-037 req=1111 same cycle, times 1,2,3,4 -> launches in order slots 0,1,2,3; each done only after its timer_done.
REQ-038 Slot 0 served, req=0011 again -> slot 1 launched before slot 0 (round-robin).
REQ-039 cancel[2] during WAIT on slot 2 -> timer_done gives no done pulse; next pending slot launches.
REQ-040 Withhold timer_done, delay=2, 4 startOfFrame strobes -> timeout_err=1, state IDLE, no done.
REQ-041 resetN pulsed low mid-WAIT with slots 1,3 pending -> all outputs 0, pending cleared, later timer_done ignored.
